// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU timing constants, sprite slot load record and visibility helper
package ppu_pkg;
  localparam int NUM_SPR_SLOTS = 8;
  localparam logic [9:0] PRERENDER_LINE = 10'd0;
  localparam logic [9:0] VIS_LINE_FIRST = 10'd1;
  localparam logic [9:0] VIS_LINE_LAST = 10'd240;
  localparam logic [9:0] VIS_DOTS = 10'd256;
  localparam logic [9:0] FETCH_END = 10'd320;
  typedef struct packed {
    logic [7:0] bmp_low;
    logic [7:0] bmp_high;
    logic [7:0] attr;
    logic [7:0] x;
  } spr_slot_t;
  function automatic logic is_visible(input logic [9:0] x_idx, input logic [9:0] scanline);
    return x_idx < VIS_DOTS && scanline >= VIS_LINE_FIRST && scanline <= VIS_LINE_LAST;
  endfunction
endpackage

// File: rtl/ppu_spr_slot.sv
// ppu_spr_slot: one sprite slot with X down-counter, pattern shifters and remaining-pixel count
module ppu_spr_slot
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic       step,
  input  spr_slot_t  data,
  output logic [3:0] pixel,
  output logic       opaque,
  output logic       behind,
  output logic       spr0
);
  logic [7:0] low, high, attr, cnt;
  logic [3:0] rem;
  logic       active;
  logic       unused_attr;
  // load wins over the line-start clear so a load on dot 256 is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low <= '0;
      high <= '0;
      attr <= '0;
      cnt <= '0;
      rem <= '0;
    end else if (load) begin
      low <= data.bmp_low;
      high <= data.bmp_high;
      attr <= data.attr;
      cnt <= data.x;
      rem <= 4'd8;
    end else if (clear) begin
      rem <= '0;
    end else if (step) begin
      if (cnt != 8'd0) cnt <= cnt - 8'd1;
      else if (rem != 4'd0) begin
        low <= low << 1;
        high <= high << 1;
        rem <= rem - 4'd1;
      end
    end
  end
  assign active = cnt == 8'd0 && rem != 4'd0;
  assign pixel = {attr[1:0], high[7], low[7]};
  assign opaque = active && (high[7] || low[7]);
  assign behind = attr[5];
  assign spr0 = attr[2];
  assign unused_attr = ^{attr[7:6], attr[4:3]};
endmodule

// File: rtl/ppu_pixel_mux.sv
// ppu_pixel_mux: sprite/background priority mux with sprite-0 hit; PPU_LEFT_CLIP_EN enables left 8-dot clipping
module ppu_pixel_mux
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       load_en,
  input  logic [2:0] load_slot,
  input  logic [7:0] load_bmp_low,
  input  logic [7:0] load_bmp_high,
  input  logic [7:0] load_attr,
  input  logic [7:0] load_x,
  input  logic [3:0] bg_pixel,
  input  logic       show_bg,
  input  logic       show_spr,
  input  logic       show_left_bg,
  input  logic       show_left_spr,
  output logic [4:0] palette_addr,
  output logic       pixel_valid,
  output logic       spr0_hit
);
  logic [3:0] pix [NUM_SPR_SLOTS];
  logic [NUM_SPR_SLOTS-1:0] opq, beh, s0;
  logic vis, in_win, clear, left_bg_ok, left_spr_ok;
  logic bg_op, spr_en, spr_op, spr_beh, hit_set, hit_clr;
  logic [3:0] spr_pix;
  logic [4:0] mux;
  spr_slot_t load_d;
  assign vis = is_visible(x_idx, scanline);
  assign in_win = x_idx >= VIS_DOTS && x_idx < FETCH_END;
  assign clear = x_idx == VIS_DOTS;
  assign load_d = '{bmp_low: load_bmp_low, bmp_high: load_bmp_high, attr: load_attr, x: load_x};
  for (genvar g = 0; g < NUM_SPR_SLOTS; g++) begin : g_slot
    ppu_spr_slot u_slot (
      .clk(clk),
      .reset_n(reset_n),
      .clear(clear),
      .load(load_en && in_win && load_slot == 3'(g)),
      .step(vis),
      .data(load_d),
      .pixel(pix[g]),
      .opaque(opq[g]),
      .behind(beh[g]),
      .spr0(s0[g])
    );
  end
`ifdef PPU_LEFT_CLIP_EN
  assign left_bg_ok = x_idx >= 10'd8 || show_left_bg;
  assign left_spr_ok = x_idx >= 10'd8 || show_left_spr;
`else
  logic unused_left;
  assign unused_left = show_left_bg ^ show_left_spr;
  assign left_bg_ok = 1'b1;
  assign left_spr_ok = 1'b1;
`endif
  // lowest-index opaque slot wins: scan downward so the last hit is the lowest index
  always_comb begin
    spr_op = 1'b0;
    spr_pix = '0;
    spr_beh = 1'b0;
    for (int i = NUM_SPR_SLOTS - 1; i >= 0; i--) begin
      if (opq[i]) begin
        spr_op = 1'b1;
        spr_pix = pix[i];
        spr_beh = beh[i];
      end
    end
  end
  assign bg_op = show_bg && left_bg_ok && bg_pixel[1:0] != 2'b00;
  assign spr_en = show_spr && left_spr_ok;
  assign mux = !(spr_op && spr_en) ? (bg_op ? {1'b0, bg_pixel} : 5'h00) :
               (bg_op && spr_beh) ? {1'b0, bg_pixel} : {1'b1, spr_pix};
  assign hit_set = vis && bg_op && spr_en && |(opq & s0) && x_idx != 10'd255;
  assign hit_clr = scanline == PRERENDER_LINE && x_idx == 10'd0;
  // registered pixel output and sticky sprite-0 hit; clear beats set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      palette_addr <= '0;
      pixel_valid <= 1'b0;
      spr0_hit <= 1'b0;
    end else begin
      palette_addr <= vis ? mux : 5'h00;
      pixel_valid <= vis;
      spr0_hit <= hit_clr ? 1'b0 : hit_set ? 1'b1 : spr0_hit;
    end
  end
endmodule

// File: tb/tb_ppu_pixel_mux.sv
// tb_ppu_pixel_mux: directed checks of priority, sprite-0 hit, left clip and reset behavior
module tb_ppu_pixel_mux;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [9:0] x_idx = '0, scanline = '0;
  logic load_en = 1'b0;
  logic [2:0] load_slot = '0;
  logic [7:0] load_bmp_low = '0, load_bmp_high = '0, load_attr = '0, load_x = '0;
  logic [3:0] bg_pixel = '0;
  logic show_bg = 1'b1, show_spr = 1'b1, show_left_bg = 1'b1, show_left_spr = 1'b1;
  logic [4:0] palette_addr;
  logic pixel_valid, spr0_hit;
  logic [3:0] bg_line [256];
  logic [4:0] out_pa [256];
  logic out_v [256];
  logic out_hit [256];
  int total = 0, bad = 0;

  ppu_pixel_mux dut (
    .clk(clk), .reset_n(reset_n), .x_idx(x_idx), .scanline(scanline),
    .load_en(load_en), .load_slot(load_slot), .load_bmp_low(load_bmp_low),
    .load_bmp_high(load_bmp_high), .load_attr(load_attr), .load_x(load_x),
    .bg_pixel(bg_pixel), .show_bg(show_bg), .show_spr(show_spr),
    .show_left_bg(show_left_bg), .show_left_spr(show_left_spr),
    .palette_addr(palette_addr), .pixel_valid(pixel_valid), .spr0_hit(spr0_hit)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bg(input logic [3:0] v);
    for (int i = 0; i < 256; i++) bg_line[i] = v;
  endtask

  task automatic run_line(input int sl, input int lo, input int hi);
    for (int x = lo; x <= hi; x++) begin
      scanline = 10'(sl);
      x_idx = 10'(x);
      bg_pixel = bg_line[x];
      step();
      out_pa[x] = palette_addr;
      out_v[x] = pixel_valid;
      out_hit[x] = spr0_hit;
    end
  endtask

  task automatic prep;
    x_idx = 10'd256;
    step();
  endtask

  task automatic load_spr(input int s, input logic [7:0] xp, input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] at);
    x_idx = 10'(257 + s);
    load_slot = 3'(s);
    load_x = xp;
    load_bmp_low = lo;
    load_bmp_high = hi;
    load_attr = at;
    load_en = 1'b1;
    step();
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    total++; if (palette_addr !== 5'h00) begin bad++; $display("FAIL reset_pa got=%h want=00", palette_addr); end
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pixel_valid); end
    total++; if (spr0_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", spr0_hit); end
    step();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_basic;
    set_bg(4'h0);
    prep();
    load_spr(0, 8'd10, 8'h80, 8'h00, 8'h00);
    run_line(1, 0, 255);
    total++; if (out_pa[10] !== 5'h11) begin bad++; $display("FAIL basic_dot10 got=%h want=11", out_pa[10]); end
    total++; if (out_v[10] !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_v[10]); end
    total++; if (out_pa[9] !== 5'h00) begin bad++; $display("FAIL basic_dot9 got=%h want=00", out_pa[9]); end
    total++; if (out_pa[11] !== 5'h00) begin bad++; $display("FAIL basic_dot11 got=%h want=00", out_pa[11]); end
    x_idx = 10'd300;
    step();
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL hblank_valid got=%b want=0", pixel_valid); end
    total++; if (palette_addr !== 5'h00) begin bad++; $display("FAIL hblank_pa got=%h want=00", palette_addr); end
  endtask

  task automatic test_priority;
    set_bg(4'h0);
    prep();
    load_spr(0, 8'd40, 8'h80, 8'h80, 8'h02);
    load_spr(1, 8'd40, 8'h80, 8'h80, 8'h03);
    run_line(2, 0, 255);
    total++; if (out_pa[40][4:2] !== 3'b110) begin bad++; $display("FAIL prio_bits got=%b want=110", out_pa[40][4:2]); end
    total++; if (out_pa[40] !== 5'h1B) begin bad++; $display("FAIL prio_pa got=%h want=1b", out_pa[40]); end
    total++; if (out_pa[41] !== 5'h00) begin bad++; $display("FAIL prio_dot41 got=%h want=00", out_pa[41]); end
  endtask

  task automatic test_behind;
    set_bg(4'h0);
    bg_line[60] = 4'h5;
    bg_line[61] = 4'h4;
    prep();
    load_spr(0, 8'd60, 8'hFF, 8'h00, 8'h20);
    run_line(3, 0, 255);
    total++; if (out_pa[60] !== 5'h05) begin bad++; $display("FAIL behind_bg got=%h want=05", out_pa[60]); end
    total++; if (out_pa[61] !== 5'h11) begin bad++; $display("FAIL behind_spr got=%h want=11", out_pa[61]); end
    show_spr = 1'b0;
    prep();
    load_spr(0, 8'd60, 8'hFF, 8'h00, 8'h20);
    run_line(4, 0, 255);
    show_spr = 1'b1;
    total++; if (out_pa[61] !== 5'h00) begin bad++; $display("FAIL spr_off got=%h want=00", out_pa[61]); end
  endtask

  task automatic test_spr0;
    set_bg(4'h5);
    prep();
    load_spr(0, 8'd255, 8'h80, 8'h00, 8'h04);
    run_line(5, 0, 255);
    total++; if (out_pa[255] !== 5'h11) begin bad++; $display("FAIL spr0_dot255_pa got=%h want=11", out_pa[255]); end
    total++; if (spr0_hit !== 1'b0) begin bad++; $display("FAIL spr0_dot255_hit got=%b want=0", spr0_hit); end
    prep();
    load_spr(0, 8'd100, 8'h80, 8'h00, 8'h04);
    run_line(6, 0, 255);
    total++; if (out_hit[99] !== 1'b0) begin bad++; $display("FAIL spr0_early got=%b want=0", out_hit[99]); end
    total++; if (out_hit[100] !== 1'b1) begin bad++; $display("FAIL spr0_set got=%b want=1", out_hit[100]); end
    scanline = 10'd241;
    x_idx = 10'd0;
    step();
    total++; if (spr0_hit !== 1'b1) begin bad++; $display("FAIL spr0_sticky got=%b want=1", spr0_hit); end
    scanline = 10'd0;
    step();
    total++; if (spr0_hit !== 1'b0) begin bad++; $display("FAIL spr0_clear got=%b want=0", spr0_hit); end
  endtask

  task automatic test_left_clip;
    logic [4:0] exp_l;
`ifdef PPU_LEFT_CLIP_EN
    exp_l = 5'h05;
`else
    exp_l = 5'h11;
`endif
    set_bg(4'h5);
    show_left_spr = 1'b0;
    prep();
    load_spr(0, 8'd3, 8'hFF, 8'h00, 8'h00);
    run_line(7, 0, 255);
    show_left_spr = 1'b1;
    total++; if (out_pa[3] !== exp_l) begin bad++; $display("FAIL clip_dot3 got=%h want=%h", out_pa[3], exp_l); end
    total++; if (out_pa[7] !== exp_l) begin bad++; $display("FAIL clip_dot7 got=%h want=%h", out_pa[7], exp_l); end
    total++; if (out_pa[8] !== 5'h11) begin bad++; $display("FAIL clip_dot8 got=%h want=11", out_pa[8]); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    set_bg(4'h5);
    prep();
    load_spr(0, 8'd100, 8'h80, 8'h00, 8'h00);
    run_line(8, 0, 49);
    total++; if (out_pa[49] !== 5'h05) begin bad++; $display("FAIL mid_pre got=%h want=05", out_pa[49]); end
    x_idx = 10'd50;
    #2 reset_n = 1'b0;
    #1;
    total++; if (palette_addr !== 5'h00) begin bad++; $display("FAIL mid_rst_pa got=%h want=00", palette_addr); end
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", pixel_valid); end
    step();
    #2 reset_n = 1'b1;
    run_line(8, 51, 255);
    total++; if (out_pa[100] !== 5'h05) begin bad++; $display("FAIL mid_slot_cleared got=%h want=05", out_pa[100]); end
    run_line(9, 0, 19);
    x_idx = 10'd20;
    bg_pixel = bg_line[20];
    load_slot = 3'd0;
    load_x = 8'd10;
    load_bmp_low = 8'hFF;
    load_bmp_high = 8'h00;
    load_attr = 8'h00;
    load_en = 1'b1;
    step();
    load_en = 1'b0;
    run_line(9, 21, 255);
    ok = 1'b1;
    for (int i = 21; i <= 60; i++) if (out_pa[i] !== 5'h05) ok = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL load_outside_window got=dots21..60 not all 05 want=all 05"); end
  endtask

  initial begin
    set_bg(4'h0);
    test_reset();
    test_basic();
    test_priority();
    test_behind();
    test_spr0();
    test_left_clip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ppu_pixel_mux.md
PPU_PIXEL_MUX -- requirements
Module: ppu_pixel_mux

Interface
REQ-001 SHALL have port clk, input, 1 bit: PPU pixel clock, rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: one clock domain; reset is asynchronous and active-low.
REQ-003 SHALL have ports x_idx and scanline, inputs, 10 bits each: current dot and scanline; scanline 0 is pre-render, scanlines 1..240 are visible.
REQ-004 SHALL have port load_en, input, 1 bit: one-cycle strobe that loads one sprite slot.
REQ-005 SHALL have port load_slot, input, 3 bits: index of the slot to load, 0..7.
REQ-006 SHALL have ports load_bmp_low and load_bmp_high, inputs, 8 bits each: pattern bytes, already horizontally flipped when required.
REQ-007 SHALL have port load_attr, input, 8 bits: [1:0] palette, [2] sprite-0 marker, [5] behind-background, other bits ignored.
REQ-008 SHALL have port load_x, input, 8 bits: sprite X position.
REQ-009 SHALL have port bg_pixel, input, 4 bits: [3:2] background palette, [1:0] pattern bits; pattern 00 is transparent.
REQ-010 SHALL have ports show_bg, show_spr, show_left_bg and show_left_spr, inputs, 1 bit each: PPUMASK enables.
REQ-011 SHALL have port palette_addr, output, 5 bits: palette RAM index.
REQ-012 SHALL have port pixel_valid, output, 1 bit: palette_addr corresponds to a visible dot.
REQ-013 SHALL have port spr0_hit, output, 1 bit: sticky sprite-0 hit flag.

Function
REQ-014 SHALL hold 8 slots, each with low/high shift registers (8 bits), attr (8 bits), X down-counter (8 bits) and a remaining-pixel count (4 bits).
REQ-015 SHALL accept load_en only when x_idx is in 256..319; on load it sets counter=load_x and remaining=8. A load outside that window is ignored.
REQ-016 SHALL, on each visible dot (x_idx < 256, scanline 1..240), decrement each slot's counter if it is nonzero; otherwise, if remaining > 0, shift both registers left one bit and decrement remaining.
REQ-017 SHALL define a slot as active when its counter is 0 and remaining > 0; the slot pixel is {attr[1:0], high[7], low[7]}, and the slot is opaque when {high[7], low[7]} != 00.
REQ-018 SHALL select the lowest-index active opaque slot; if there is none, the sprite is transparent.
REQ-019 SHALL apply this priority: both transparent -> 5'h00; background opaque only -> {0, bg_pixel}; sprite opaque only -> {1, sprite pixel}; both opaque -> background when attr[5]=1, else sprite.
REQ-020 SHALL treat the background as transparent when show_bg=0, and the sprite as transparent when show_spr=0.
REQ-021 SHALL register palette_addr and pixel_valid, giving 1-cycle latency from x_idx; pixel_valid=0 and palette_addr=0 outside visible dots.
REQ-022 SHALL set spr0_hit when the selected-or-any active opaque slot with attr[2]=1 coincides with an opaque background, show_bg=1, show_spr=1, and x_idx != 255.
REQ-023 SHALL keep spr0_hit sticky until scanline 0, x_idx 0, where it clears; a simultaneous set and clear resolves as clear.
REQ-024 SHALL leave a slot that is never loaded on a line with remaining=0 (transparent), because remaining clears at x_idx 256 of each line before loads.

Reset
REQ-025 SHALL, while reset_n=0, clear all slot registers, palette_addr=0, pixel_valid=0 and spr0_hit=0, regardless of clk.
REQ-026 SHALL, on reset release mid-line, keep all slots transparent until they are reloaded.

Configuration
REQ-027 SHALL, with PPU_LEFT_CLIP_EN defined, treat the background as transparent when show_left_bg=0 and the sprite as transparent when show_left_spr=0 for x_idx 0..7, and suppress spr0_hit on those dots.
REQ-028 SHALL, without PPU_LEFT_CLIP_EN, ignore show_left_bg and show_left_spr and treat them as 1.

Structure
REQ-029 SHALL place in shared package ppu_pkg: NUM_SPR_SLOTS=8, PRERENDER_LINE=0, VIS_LINE_FIRST=1, VIS_LINE_LAST=240, VIS_DOTS=256, FETCH_END=320, and struct spr_slot_t (bmp_low, bmp_high, attr, x).
REQ-030 SHALL implement one slot as sub-module ppu_spr_slot, instantiated 8 times in a generate loop, with the priority mux in the parent.

Verification
REQ-031 SHALL cover: slot 0 loaded with x=10, low=8'h80, high=0, attr=0, bg transparent -> palette_addr=5'h11 on dot 10 (valid on cycle 11), 5'h00 on dots 9 and 11.
REQ-032 SHALL cover: slots 0 and 1 opaque at the same x, slot 0 pal 2, slot 1 pal 3 -> slot 0 wins, palette_addr[4:2]=3'b110.
REQ-033 SHALL cover: sprite attr[5]=1 with bg_pixel=4'h5 -> palette_addr=5'h05; with bg_pixel=4'h4 -> the sprite color is output.
REQ-034 SHALL cover: sprite-0 slot at x=255 with opaque bg -> no hit; at x=100 -> spr0_hit=1 and held until scanline 0 dot 0.
REQ-035 SHALL cover: PPU_LEFT_CLIP_EN defined, show_left_spr=0, sprite at x=3 -> dots 3..7 show bg; undefined -> sprite shown.
REQ-036 SHALL cover: reset_n pulsed low at dot 50 -> outputs 0 immediately; slots transparent until reload; load_en at dot 20 is ignored.
